// File: rtl/noobs_dmem_uart_bridge_pkg.sv
// Shared definitions for the data-memory UART bridge: IO register map,
// STATUS byte layout and the transmitter state encoding.
package noobs_dmem_uart_bridge_pkg;

  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h1;
  localparam logic [3:0] REG_BAUDLO = 4'h2;
  localparam logic [3:0] REG_BAUDHI = 4'h3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic logic [7:0] pack_status(input logic [3:0] count, input logic ovf,
                                             input logic busy, input logic full,
                                             input logic empty);
    logic [7:0] st;
    st                          = 8'h00;
    st[ST_EMPTY]                = empty;
    st[ST_FULL]                 = full;
    st[ST_BUSY]                 = busy;
    st[ST_OVF]                  = ovf;
    st[ST_COUNT_LSB+3:ST_COUNT_LSB] = count;
    return st;
  endfunction

endpackage

// File: rtl/noobs_sync_fifo.sv
// Byte-wide synchronous FIFO; pushes while full and pops while empty are ignored,
// fullness is judged on the occupancy at the start of the cycle.
module noobs_sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign rd_data   = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage array, written at the tail pointer
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/noobs_dmem_uart_bridge.sv
// CPU data-port bridge: forwards accesses to the data SRAM except for a 16-byte
// IO window that hosts a FIFO-buffered 8N1 UART transmitter.
module noobs_dmem_uart_bridge
  import noobs_dmem_uart_bridge_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter logic [11:0] IO_BASE      = 12'hFF0,
  parameter logic [11:0] BAUD_DIV_RST = 12'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] m_addr,
  input  logic [7:0]  m_wr_data,
  input  logic        m_en,
  input  logic        m_rd,
  input  logic        m_wr,
  output logic [7:0]  m_rd_data,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_wr_data,
  output logic        ram_en,
  output logic        ram_rd,
  output logic        ram_wr,
  input  logic [7:0]  ram_rd_data,
  output logic        uart_tx
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          io_hit_s;
  logic          io_wr_s;
  logic [3:0]    offset_s;
  logic [7:0]    io_rdata_s;
  logic [7:0]    io_rdata_r;
  logic          io_hit_q_r;
  logic          ram_rd_q_r;
  logic [11:0]   baud_div_r;
  logic [11:0]   baud_cnt_r;
  logic          overflow_r;
  tx_state_e     state_r;
  logic [7:0]    shift_r;
  logic [2:0]    bit_idx_r;
  logic          uart_tx_r;
  logic          fifo_push_s;
  logic          fifo_pop_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [7:0]    fifo_head_s;
  logic [CW-1:0] fifo_count_s;

  assign io_hit_s    = m_en & (m_addr[11:4] == IO_BASE[11:4]);
  assign offset_s    = m_addr[3:0];
  assign io_wr_s     = io_hit_s & m_wr;
  assign ram_addr    = m_addr;
  assign ram_wr_data = m_wr_data;
  assign ram_en      = m_en & ~io_hit_s;
  assign ram_rd      = m_rd & ~io_hit_s;
  assign ram_wr      = m_wr & ~io_hit_s;
  assign fifo_push_s = io_wr_s & (offset_s == REG_TXDATA);
  assign fifo_pop_s  = (state_r == IDLE) & ~fifo_empty_s;
  assign uart_tx     = uart_tx_r;

  // SRAM data only appears on the read port after a real SRAM read, so idle cycles read 0
  assign m_rd_data = io_hit_q_r ? io_rdata_r : (ram_rd_q_r ? ram_rd_data : 8'h00);

  noobs_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push_s),
    .wr_data (m_wr_data),
    .pop     (fifo_pop_s),
    .rd_data (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // IO read mux, evaluated in the request cycle
  always_comb begin
    io_rdata_s = 8'h00;
    case (offset_s)
      REG_STATUS: io_rdata_s = pack_status(4'(fifo_count_s), overflow_r, (state_r != IDLE),
                                           fifo_full_s, fifo_empty_s);
      REG_BAUDLO: io_rdata_s = baud_div_r[7:0];
      REG_BAUDHI: io_rdata_s = {4'h0, baud_div_r[11:8]};
      default:    io_rdata_s = 8'h00;
    endcase
  end

  // Register file writes and the one-cycle read pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_div_r <= BAUD_DIV_RST;
      overflow_r <= 1'b0;
      io_hit_q_r <= 1'b0;
      ram_rd_q_r <= 1'b0;
      io_rdata_r <= 8'h00;
    end else begin
      io_hit_q_r <= io_hit_s;
      ram_rd_q_r <= m_en & m_rd & ~io_hit_s;
      io_rdata_r <= io_rdata_s;
      if (io_wr_s) begin
        case (offset_s)
          REG_TXDATA: if (fifo_full_s) overflow_r <= 1'b1;
          REG_STATUS: if (m_wr_data[ST_OVF]) overflow_r <= 1'b0;
          REG_BAUDLO: baud_div_r[7:0]  <= m_wr_data;
          REG_BAUDHI: baud_div_r[11:8] <= m_wr_data[3:0];
          default:    ;
        endcase
      end
    end
  end

  // Serialiser; the bit counter reloads from baud_div only at bit boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      shift_r    <= 8'h00;
      bit_idx_r  <= 3'd0;
      baud_cnt_r <= 12'd0;
      uart_tx_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          uart_tx_r <= 1'b1;
          if (!fifo_empty_s) begin
            shift_r    <= fifo_head_s;
            baud_cnt_r <= baud_div_r;
            uart_tx_r  <= 1'b0;
            state_r    <= START;
          end
        end
        START: begin
          if (baud_cnt_r == 12'd0) begin
            baud_cnt_r <= baud_div_r;
            bit_idx_r  <= 3'd0;
            uart_tx_r  <= shift_r[0];
            state_r    <= DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r - 12'd1;
          end
        end
        DATA: begin
          if (baud_cnt_r == 12'd0) begin
            baud_cnt_r <= baud_div_r;
            if (bit_idx_r == 3'd7) begin
              uart_tx_r <= 1'b1;
              state_r   <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              uart_tx_r <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - 12'd1;
          end
        end
        STOP: begin
          if (baud_cnt_r == 12'd0) begin
            state_r <= IDLE;
          end else begin
            baud_cnt_r <= baud_cnt_r - 12'd1;
          end
        end
        default: begin
          state_r   <= IDLE;
          uart_tx_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noobs_dmem_uart_bridge.sv
// Self-checking bench for noobs_dmem_uart_bridge: read data goes through a
// scoreboard queue, serial frames are checked bit by bit against the written bytes.
module tb_noobs_dmem_uart_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] m_addr;
  logic [7:0]  m_wr_data;
  logic        m_en;
  logic        m_rd;
  logic        m_wr;
  logic [7:0]  m_rd_data;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wr_data;
  logic        ram_en;
  logic        ram_rd;
  logic        ram_wr;
  logic [7:0]  ram_rd_data = 8'h00;
  logic        uart_tx;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  exp_q [$];
  logic [11:0] addr_q [$];
  logic        rd_pend = 1'b0;
  logic [7:0]  sram [4096];

  int waited;
  int w;
  int lows;
  int per [10];

  always #5 clk = ~clk;

  noobs_dmem_uart_bridge #(
    .DEPTH        (8),
    .IO_BASE      (12'hFF0),
    .BAUD_DIV_RST (12'd433)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m_addr      (m_addr),
    .m_wr_data   (m_wr_data),
    .m_en        (m_en),
    .m_rd        (m_rd),
    .m_wr        (m_wr),
    .m_rd_data   (m_rd_data),
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .ram_en      (ram_en),
    .ram_rd      (ram_rd),
    .ram_wr      (ram_wr),
    .ram_rd_data (ram_rd_data),
    .uart_tx     (uart_tx)
  );

  // SRAM model with one-cycle read latency
  always @(posedge clk) begin
    if (ram_en && ram_wr) sram[ram_addr] <= ram_wr_data;
    if (ram_en && ram_rd) ram_rd_data <= sram[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Read scoreboard: a read issued in one cycle is compared in the next
  always @(posedge clk) rd_pend <= reset ? 1'b0 : (m_en & m_rd);

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
      else check_eq($sformatf("rd_%03h", addr_q.pop_front()), m_rd_data, exp_q.pop_front());
    end
  end

  task automatic bus(input logic [11:0] a, input logic [7:0] d, input logic rd,
                     input logic wr, input logic [7:0] exp_rd);
    logic in_win;
    in_win    = (a[11:4] == 8'hFF);
    m_addr    = a;
    m_wr_data = d;
    m_en      = 1'b1;
    m_rd      = rd;
    m_wr      = wr;
    if (rd) begin
      exp_q.push_back(exp_rd);
      addr_q.push_back(a);
    end
    @(negedge clk);
    check_eq($sformatf("ram_en_%03h", a), ram_en, !in_win);
    check_eq($sformatf("ram_wr_%03h", a), ram_wr, wr & !in_win);
    if (!in_win) begin
      check_eq("ram_rd", ram_rd, rd);
      check_eq("ram_addr", ram_addr, a);
      if (wr) check_eq("ram_wr_data", ram_wr_data, d);
    end
    @(posedge clk); #1;
    m_en = 1'b0;
    m_rd = 1'b0;
    m_wr = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then checks every clock of every bit
  task automatic expect_frame(input logic [7:0] data, input int p [10], input int max_wait,
                              output int nwait);
    logic [9:0] bits;
    int good;
    bits  = {1'b1, data, 1'b0};
    nwait = 0;
    @(negedge clk);
    while (uart_tx !== 1'b0 && nwait < max_wait) begin
      nwait++;
      @(negedge clk);
    end
    if (uart_tx !== 1'b0) begin
      check_eq("frame_start_timeout", uart_tx, 32'd0);
      return;
    end
    for (int k = 0; k < 10; k++) begin
      good = 0;
      for (int c = 0; c < p[k]; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (uart_tx === bits[k]) good++;
      end
      check_eq($sformatf("frame_%02h_bit%0d", data, k), good, p[k]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    m_addr = 12'h000;
    m_wr_data = 8'h00;
    m_en = 1'b0;
    m_rd = 1'b0;
    m_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_uart_tx", uart_tx, 32'd1);
    check_eq("rst_m_rd_data", m_rd_data, 32'd0);
    @(posedge clk); #1;

    // Reset register values and unused offsets
    bus(12'hFF1, 8'h00, 1'b1, 1'b0, 8'h01);
    bus(12'hFF2, 8'h00, 1'b1, 1'b0, 8'hB1);
    bus(12'hFF3, 8'h00, 1'b1, 1'b0, 8'h01);
    bus(12'hFF0, 8'h00, 1'b1, 1'b0, 8'h00);
    bus(12'hFF7, 8'h00, 1'b1, 1'b0, 8'h00);

    // SRAM passthrough
    bus(12'h123, 8'hA7, 1'b0, 1'b1, 8'h00);
    bus(12'h200, 8'h3C, 1'b0, 1'b1, 8'h00);
    bus(12'h123, 8'h00, 1'b1, 1'b0, 8'hA7);
    bus(12'h200, 8'h00, 1'b1, 1'b0, 8'h3C);

    // baud_div = 3; BAUDHI upper nibble is not stored
    bus(12'hFF2, 8'h03, 1'b0, 1'b1, 8'h00);
    bus(12'hFF3, 8'hF0, 1'b0, 1'b1, 8'h00);
    bus(12'hFF2, 8'h00, 1'b1, 1'b0, 8'h03);
    bus(12'hFF3, 8'h00, 1'b1, 1'b0, 8'h00);

    // Two back-to-back bytes: second write returns in the first START cycle
    bus(12'hFF0, 8'h55, 1'b0, 1'b1, 8'h00);
    bus(12'hFF0, 8'hA3, 1'b0, 1'b1, 8'h00);
    foreach (per[i]) per[i] = 4;
    expect_frame(8'h55, per, 20, waited);
    check_eq("start_latency", waited, 32'd0);
    expect_frame(8'hA3, per, 20, waited);
    check_eq("frame_gap", waited, 32'd1);
    @(negedge clk);
    check_eq("idle_after_frames", uart_tx, 32'd1);
    @(posedge clk); #1;
    bus(12'hFF1, 8'h00, 1'b1, 1'b0, 8'h01);

    // Divisor raised to 7 in the middle of data bit 2
    bus(12'hFF0, 8'h55, 1'b0, 1'b1, 8'h00);
    per = '{4, 4, 4, 4, 8, 8, 8, 8, 8, 8};
    fork
      expect_frame(8'h55, per, 20, waited);
      begin
        w = 0;
        @(negedge clk);
        while (uart_tx !== 1'b0 && w < 20) begin
          w++;
          @(negedge clk);
        end
        repeat (13) @(posedge clk);
        #1;
        bus(12'hFF2, 8'h07, 1'b0, 1'b1, 8'h00);
      end
    join
    @(posedge clk); #1;

    // Fill the FIFO at baud_div = 100, then overflow and clear
    bus(12'hFF2, 8'd100, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 9; i++) bus(12'hFF0, 8'h11 + 8'(i), 1'b0, 1'b1, 8'h00);
    bus(12'hFF1, 8'h00, 1'b1, 1'b0, 8'h86);
    bus(12'hFF0, 8'hEE, 1'b0, 1'b1, 8'h00);
    bus(12'hFF1, 8'h00, 1'b1, 1'b0, 8'h8E);
    bus(12'hFF1, 8'hF7, 1'b0, 1'b1, 8'h00);
    bus(12'hFF1, 8'h00, 1'b1, 1'b0, 8'h8E);
    bus(12'hFF1, 8'h08, 1'b0, 1'b1, 8'h00);
    bus(12'hFF1, 8'h00, 1'b1, 1'b0, 8'h86);

    // Reset during data bit 0 of byte 0x11 discards the frame and the queued bytes
    repeat (120) @(posedge clk);
    @(negedge clk);
    check_eq("pre_reset_data_bit0", uart_tx, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset_abort_tx", uart_tx, 32'd1);
    check_eq("reset_abort_rd_data", m_rd_data, 32'd0);
    @(posedge clk); #1;
    bus(12'hFF1, 8'h00, 1'b1, 1'b0, 8'h01);
    bus(12'hFF2, 8'h00, 1'b1, 1'b0, 8'hB1);
    lows = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check_eq("no_frame_after_reset", lows, 32'd0);

    @(posedge clk); #1;
    check_eq("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/noobs_dmem_uart_bridge.md
# noobs_dmem_uart_bridge

Data-memory-side bridge between the CPU core's data-memory port and the external 4 KB data SRAM. It claims a 16-byte memory-mapped IO window at the top of the 12-bit address space. Inside that window it implements a buffered 8N1 UART transmitter with a programmable baud divisor. All other accesses pass straight through to the SRAM.

## Interface
Parameters:
- DEPTH, 8, TX FIFO entries; legal values 2, 4, 8
- IO_BASE, 12'hFF0, base of the 16-byte IO window; low nibble must be 0
- BAUD_DIV_RST, 12'd433, reset value of the baud divisor

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- m_addr  in  12  CPU data address
- m_wr_data  in  8  CPU write data
- m_en  in  1  CPU access enable
- m_rd  in  1  CPU read strobe
- m_wr  in  1  CPU write strobe
- m_rd_data  out  8  read data to CPU
- ram_addr  out  12  SRAM address (m_addr passthrough)
- ram_wr_data  out  8  SRAM write data (m_wr_data passthrough)
- ram_en  out  1  SRAM enable
- ram_rd  out  1  SRAM read strobe
- ram_wr  out  1  SRAM write strobe
- ram_rd_data  in  8  SRAM read data, valid one cycle after ram_en&ram_rd
- uart_tx  out  1  serial output, idles high

## Operation
- io_hit = m_en & (m_addr[11:4] == IO_BASE[11:4]).
- ram_en/ram_rd/ram_wr = m_en/m_rd/m_wr gated by ~io_hit. These are combinational.
- Register map, as offset m_addr[3:0]:
  - 0x0 TXDATA: a write pushes the byte into the FIFO; a read returns 0.
  - 0x1 STATUS (read):
    - bit0 fifo_empty
    - bit1 fifo_full
    - bit2 tx_busy (FSM not IDLE)
    - bit3 overflow (sticky)
    - bits7:4 FIFO count
  - 0x1 STATUS (write): writing 1 to bit3 clears overflow; all other bits are ignored.
  - 0x2 BAUDLO: read/write, baud_div[7:0].
  - 0x3 BAUDHI: read/write; bits3:0 hold baud_div[11:8], bits7:4 read 0.
  - 0x4–0xF: reads return 0, writes are ignored.
- Push to a full FIFO: the byte is dropped and overflow is set. Fullness is judged on the count before the cycle, even if a pop happens in the same cycle.
- Simultaneous push and pop (FIFO not full): count is unchanged and both complete.
- Transmitter FSM:
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: uart_tx=0 for one bit period.
  - DATA: 8 bits, LSB first, one bit period each; a 3-bit index counts 0..7.
  - STOP: uart_tx=1 for one bit period, then IDLE.
- Bit period = baud_div+1 clocks. A down-counter is reloaded from baud_div at every bit boundary.
- A baud_div write mid-frame takes effect at the next bit boundary; the current bit is not stretched.
- m_en with both m_rd and m_wr set is illegal and produces undefined results. Outside the IO window it is forwarded unchanged.

## Timing
- Read latency is 1 cycle for both SRAM and IO reads.
- io_hit and offset are registered at the request. The cycle after, m_rd_data = registered IO value if io_hit_q, else ram_rd_data.
- IO read values are sampled in the request cycle.
- IO writes take effect at the clock edge ending the request cycle. A STATUS read in the next cycle reflects that write.
- A push into an empty FIFO while in IDLE:
  - cycle N+1: pop, enter START
  - cycle N+2 onward: uart_tx=0
- Frame length = 10·(baud_div+1) clocks.
- Back-to-back frames have one IDLE clock between STOP and the next START.
- Reset values:
  - FIFO empty, pointers 0, overflow 0
  - baud_div = BAUD_DIV_RST
  - FSM IDLE, uart_tx=1
  - m_rd_data=0, io_hit_q=0
- Reset mid-frame aborts immediately: uart_tx=1 on the next cycle and FIFO contents are discarded.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

## Structure
- Shared package holds:
  - register offset constants: TXDATA, STATUS, BAUDLO, BAUDHI
  - STATUS bit positions
  - the FSM state enum: IDLE, START, DATA, STOP
- One sub-module, noobs_sync_fifo: DEPTH×8, push/pop/full/empty/count, synchronous active-high reset.
- Address decode, register file, read mux and the TX FSM live in the top of this block.

## Test plan
- Reset, then read STATUS at 0xFF1 -> 0x01 one cycle later; BAUDLO reads 0xB1, BAUDHI reads 0x01; uart_tx=1.
- Write 0x55 to 0xFF0 with baud_div=3 -> START at cycle +2, bit stream 1,0,1,0,1,0,1,0 LSB first, each bit 4 clocks, STOP, back to IDLE; frame is 40 clocks.
- Write 9 bytes back-to-back with baud_div=100 -> first byte pops, 8 buffered; STATUS=0x86; 9th write not dropped.
  - Ten back-to-back writes -> 10th dropped; STATUS=0x8E (full, busy, overflow); write 0x08 to 0xFF1 -> overflow clears.
- SRAM passthrough: read at 0x123 -> ram_en=1, ram_rd=1, ram_addr=0x123 same cycle; ram_rd_data=0xA7 returned on m_rd_data next cycle. Write to 0xFF2 -> ram_en stays 0.
- Change baud_div from 3 to 7 in the middle of bit 2 -> bit 2 lasts 4 clocks; bit 3 onward lasts 8 clocks.
- Assert reset during the DATA state -> uart_tx=1 and STATUS=0x01 after reset deasserts; no further frame is sent.
